// File: rtl/mem_pkg.sv
// Shared definitions for the memory access stage: opcodes, FSM states,
// access sizes, default ack-wait limit and byte-lane helper functions.
package mem_pkg;

  localparam int DM_WAIT_MAX_DEF = 15;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Unknown opcodes fall back to a full word access.
  function automatic size_t op_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
      default:              op_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic op_unsigned(input logic [5:0] op);
    op_unsigned = (op == OP_LBU) || (op == OP_LHU);
  endfunction

  // Little-endian byte enables; halves use addr[1], words always lane 0.
  function automatic logic [3:0] lane_be(input size_t sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: lane_be = 4'b0001 << lo;
      SZ_HALF: lane_be = 4'b0011 << {lo[1], 1'b0};
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across all lanes so any enabled lane is correct.
  function automatic logic [31:0] store_data(input size_t sz, input logic [31:0] d);
    case (sz)
      SZ_BYTE: store_data = {4{d[7:0]}};
      SZ_HALF: store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Combinational load formatter: picks the addressed lane out of the read
// word and sign- or zero-extends it to 32 bits.
module mem_load_extend
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  size_t       size_i,
  input  logic        uns_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection followed by extension according to access size.
  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_s = rdata_i[7:0];
      2'd1:    byte_s = rdata_i[15:8];
      2'd2:    byte_s = rdata_i[23:16];
      default: byte_s = rdata_i[31:24];
    endcase
    if (addr_lo_i[1]) begin
      half_s = rdata_i[31:16];
    end else begin
      half_s = rdata_i[15:0];
    end
    case (size_i)
      SZ_BYTE: data_o = {{24{~uns_i & byte_s[7]}}, byte_s};
      SZ_HALF: data_o = {{16{~uns_i & half_s[15]}}, half_s};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access pipeline stage: passes ALU results through in one cycle and
// runs loads/stores against a handshaked data memory (IDLE/ACCESS/DONE),
// with an ack-wait timeout. Optional alignment checking is enabled by
// defining MEM_ALIGN_CHECK_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DM_WAIT_MAX = DM_WAIT_MAX_DEF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] instruction_in,
  input  logic [31:0] hilowrite_in,
  input  logic [31:0] ReadData2_in,
  input  logic [4:0]  WriteReg_in,
  input  logic        RegWrite_in,
  input  logic        nowrite_in,
  input  logic        MemWrite_in,
  input  logic        MemRead_in,
  input  logic        stall_in,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        mem_stall,
  output logic [31:0] wb_data_out,
  output logic [4:0]  WriteReg_out,
  output logic        RegWrite_out,
  output logic        nowrite_out,
  output logic        valid_out,
  output logic        align_err,
  output logic        timeout_err
);

  state_t      state_q, state_d;
  logic [31:0] wait_q, wait_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  size_t       size_q, size_d;
  logic        uns_q, uns_d;
  logic [4:0]  wreg_q, wreg_d;
  logic        regw_q, regw_d;
  logic        nowr_q, nowr_d;

  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wreg_out_q, wreg_out_d;
  logic        regw_out_q, regw_out_d;
  logic        nowr_out_q, nowr_out_d;
  logic        valid_q, valid_d;
  logic        align_err_q, align_err_d;
  logic        timeout_q, timeout_d;

  size_t       size_s;
  logic        mem_op_s;
  logic        misalign_s;
  logic        in_access_s;
  logic [31:0] load_s;
  logic        unused_s;

  assign unused_s    = ^instruction_in[25:0];
  assign size_s      = op_size(instruction_in[31:26]);
  assign mem_op_s    = MemRead_in | MemWrite_in;
  assign in_access_s = (state_q == ACCESS);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_s = ((size_s == SZ_HALF) && hilowrite_in[0]) ||
                      ((size_s == SZ_WORD) && (hilowrite_in[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  mem_load_extend u_load_extend (
    .rdata_i   (dm_rdata),
    .size_i    (size_q),
    .uns_i     (uns_q),
    .addr_lo_i (addr_q[1:0]),
    .data_o    (load_s)
  );

  // Stage control: next state, operation latch and registered outputs.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wreg_d      = wreg_q;
    regw_d      = regw_q;
    nowr_d      = nowr_q;
    wb_data_d   = 32'd0;
    wreg_out_d  = 5'd0;
    regw_out_d  = 1'b0;
    nowr_out_d  = 1'b0;
    valid_d     = 1'b0;
    align_err_d = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (stall_in) begin
          state_d = IDLE;
        end else if (mem_op_s) begin
          we_d    = MemWrite_in;
          addr_d  = hilowrite_in;
          be_d    = lane_be(size_s, hilowrite_in[1:0]);
          wdata_d = store_data(size_s, ReadData2_in);
          size_d  = size_s;
          uns_d   = op_unsigned(instruction_in[31:26]);
          wreg_d  = WriteReg_in;
          regw_d  = RegWrite_in;
          nowr_d  = nowrite_in;
          wait_d  = 32'd0;
          if (misalign_s) begin
            state_d     = DONE;
            align_err_d = 1'b1;
            valid_d     = 1'b1;
            wreg_out_d  = WriteReg_in;
            nowr_out_d  = nowrite_in;
          end else begin
            state_d = ACCESS;
          end
        end else begin
          wb_data_d  = hilowrite_in;
          wreg_out_d = WriteReg_in;
          regw_out_d = RegWrite_in;
          nowr_out_d = nowrite_in;
          valid_d    = 1'b1;
        end
      end
      ACCESS: begin
        if (dm_ack) begin
          state_d    = DONE;
          valid_d    = 1'b1;
          wreg_out_d = wreg_q;
          nowr_out_d = nowr_q;
          if (we_q) begin
            regw_out_d = 1'b0;
          end else begin
            regw_out_d = regw_q;
            wb_data_d  = load_s;
          end
        end else if (wait_q == 32'(DM_WAIT_MAX - 1)) begin
          state_d    = DONE;
          timeout_d  = 1'b1;
          valid_d    = 1'b1;
          wreg_out_d = wreg_q;
          nowr_out_d = nowr_q;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      wait_q      <= 32'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      be_q        <= 4'd0;
      wdata_q     <= 32'd0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      wreg_q      <= 5'd0;
      regw_q      <= 1'b0;
      nowr_q      <= 1'b0;
      wb_data_q   <= 32'd0;
      wreg_out_q  <= 5'd0;
      regw_out_q  <= 1'b0;
      nowr_out_q  <= 1'b0;
      valid_q     <= 1'b0;
      align_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wreg_q      <= wreg_d;
      regw_q      <= regw_d;
      nowr_q      <= nowr_d;
      wb_data_q   <= wb_data_d;
      wreg_out_q  <= wreg_out_d;
      regw_out_q  <= regw_out_d;
      nowr_out_q  <= nowr_out_d;
      valid_q     <= valid_d;
      align_err_q <= align_err_d;
      timeout_q   <= timeout_d;
    end
  end

  // Upstream freezes while a memory op is pending or in flight.
  assign mem_stall = in_access_s | ((state_q == IDLE) & ~stall_in & mem_op_s);

  assign dm_req   = in_access_s;
  assign dm_we    = in_access_s & we_q;
  assign dm_addr  = in_access_s ? {addr_q[31:2], 2'b00} : 32'd0;
  assign dm_be    = in_access_s ? be_q : 4'd0;
  assign dm_wdata = in_access_s ? wdata_q : 32'd0;

  assign wb_data_out  = wb_data_q;
  assign WriteReg_out = wreg_out_q;
  assign RegWrite_out = regw_out_q;
  assign nowrite_out  = nowr_out_q;
  assign valid_out    = valid_q;
  assign timeout_err  = timeout_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign align_err = align_err_q;
`else
  assign align_err = 1'b0 & align_err_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// ALU/bubble/load/store traffic checked against a byte-lane reference model.
module tb_mem_access_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] instruction_in, hilowrite_in, ReadData2_in;
  logic [4:0]  WriteReg_in;
  logic        RegWrite_in, nowrite_in, MemWrite_in, MemRead_in, stall_in;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        mem_stall, RegWrite_out, nowrite_out, valid_out, align_err, timeout_err;
  logic [31:0] wb_data_out;
  logic [4:0]  WriteReg_out;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit dut (
    .Clk(Clk), .Rst(Rst),
    .instruction_in(instruction_in), .hilowrite_in(hilowrite_in),
    .ReadData2_in(ReadData2_in), .WriteReg_in(WriteReg_in),
    .RegWrite_in(RegWrite_in), .nowrite_in(nowrite_in),
    .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in), .stall_in(stall_in),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_stall(mem_stall), .wb_data_out(wb_data_out), .WriteReg_out(WriteReg_out),
    .RegWrite_out(RegWrite_out), .nowrite_out(nowrite_out), .valid_out(valid_out),
    .align_err(align_err), .timeout_err(timeout_err)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    instruction_in = 32'd0; hilowrite_in = 32'd0; ReadData2_in = 32'd0;
    WriteReg_in = 5'd0; RegWrite_in = 1'b0; nowrite_in = 1'b0;
    MemWrite_in = 1'b0; MemRead_in = 1'b0; stall_in = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_dm_req"}, {31'd0, dm_req}, 32'd0);
    check_val({tag, "_wb"}, wb_data_out, 32'd0);
    check_val({tag, "_wreg"}, {27'd0, WriteReg_out}, 32'd0);
    check_val({tag, "_flags"},
              {27'd0, RegWrite_out, nowrite_out, valid_out, align_err, timeout_err}, 32'd0);
    check_val({tag, "_stall"}, {31'd0, mem_stall}, 32'd0);
  endtask

  // Non-memory op (stall=0) or bubble (stall=1); mem request bits may be set on bubbles.
  task automatic run_alu(input logic [31:0] val, input logic [4:0] wreg, input logic regw,
                         input logic nowr, input logic stall, input logic mr, input logic mw);
    @(posedge Clk); #1;
    instruction_in = {6'h00, 26'(val)}; hilowrite_in = val; ReadData2_in = ~val;
    WriteReg_in = wreg; RegWrite_in = regw; nowrite_in = nowr;
    MemRead_in = mr; MemWrite_in = mw; stall_in = stall;
    @(negedge Clk);
    check_val("alu_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge Clk); #1;
    idle_inputs();
    @(negedge Clk);
    check_val("alu_valid", {31'd0, valid_out}, {31'd0, ~stall});
    check_val("alu_regw", {31'd0, RegWrite_out}, {31'd0, regw & ~stall});
    check_val("alu_dmreq", {31'd0, dm_req}, 32'd0);
    if (!stall) begin
      check_val("alu_wb", wb_data_out, val);
      check_val("alu_wreg", {27'd0, WriteReg_out}, {27'd0, wreg});
      check_val("alu_nowr", {31'd0, nowrite_out}, {31'd0, nowr});
    end
  endtask

  // Load/store with acknowledgement after 'waits' idle cycles; model derives expectations.
  task automatic run_mem(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic wr, input logic rd, input logic regw, input logic [4:0] wreg,
                         input int waits, input logic [31:0] rdata);
    int sz, lane, stalls;
    logic sgn, misal;
    logic [31:0] exp_be, exp_wd, mask, ld;
    case (op)
      6'h20, 6'h24, 6'h28: sz = 1;
      6'h21, 6'h25, 6'h29: sz = 2;
      default:             sz = 4;
    endcase
    sgn  = (op == 6'h20) || (op == 6'h21);
    lane = (sz == 1) ? int'(addr[1:0]) : (sz == 2) ? 2 * int'(addr[1]) : 0;
    exp_be = ((32'd1 << sz) - 32'd1) << lane;
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = data[8*(i % sz) +: 8];
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
    ld   = (rdata >> (8*lane)) & mask;
    if (sgn && ld[8*sz-1]) ld = ld | ~mask;
`ifdef MEM_ALIGN_CHECK_EN
    misal = ((sz == 2) && addr[0]) || ((sz == 4) && (addr[1:0] != 2'b00));
`else
    misal = 1'b0;
`endif
    stalls = 0;
    @(posedge Clk); #1;
    instruction_in = {op, 26'($urandom)}; hilowrite_in = addr; ReadData2_in = data;
    MemWrite_in = wr; MemRead_in = rd; RegWrite_in = regw; WriteReg_in = wreg;
    nowrite_in = 1'b0; stall_in = 1'b0;
    @(negedge Clk);
    check_val("mem_idle_stall", {31'd0, mem_stall}, 32'd1);
    check_val("mem_idle_req", {31'd0, dm_req}, 32'd0);
    stalls += int'(mem_stall);
    @(posedge Clk); #1;
    if (misal) begin
      idle_inputs();
      @(negedge Clk);
      check_val("align_err", {31'd0, align_err}, 32'd1);
      check_val("align_req", {31'd0, dm_req}, 32'd0);
      check_val("align_regw", {31'd0, RegWrite_out}, 32'd0);
      check_val("align_stall", {31'd0, mem_stall}, 32'd0);
      @(negedge Clk);
      check_val("align_pulse", {31'd0, align_err}, 32'd0);
    end else begin
      for (int w = 0; w <= waits; w++) begin
        @(negedge Clk);
        check_val("acc_req", {31'd0, dm_req}, 32'd1);
        check_val("acc_addr", dm_addr, {addr[31:2], 2'b00});
        check_val("acc_be", {28'd0, dm_be}, exp_be);
        check_val("acc_we", {31'd0, dm_we}, {31'd0, wr});
        if (wr) check_val("acc_wdata", dm_wdata, exp_wd);
        stalls += int'(mem_stall);
        dm_rdata = (w == waits) ? rdata : $urandom;
        dm_ack   = (w == waits);
        @(posedge Clk); #1;
        dm_ack = 1'b0;
      end
      idle_inputs();
      @(negedge Clk);
      check_val("done_valid", {31'd0, valid_out}, 32'd1);
      check_val("done_regw", {31'd0, RegWrite_out}, {31'd0, regw & ~wr});
      check_val("done_wreg", {27'd0, WriteReg_out}, {27'd0, wreg});
      check_val("done_stall", {31'd0, mem_stall}, 32'd0);
      check_val("done_req", {31'd0, dm_req}, 32'd0);
      check_val("done_tmo", {31'd0, timeout_err}, 32'd0);
      if (!wr) check_val("done_wb", wb_data_out, ld);
      check_val("stall_cycles", stalls, waits + 2);
    end
  endtask

  task automatic run_timeout();
    int stalls = 0;
    @(posedge Clk); #1;
    instruction_in = {6'h23, 26'd0}; hilowrite_in = 32'h40; MemRead_in = 1'b1;
    MemWrite_in = 1'b0; RegWrite_in = 1'b1; WriteReg_in = 5'd9; stall_in = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge Clk);
      if (c > 0) check_val("tmo_req_hold", {31'd0, dm_req}, 32'd1);
      stalls += int'(mem_stall);
      @(posedge Clk); #1;
    end
    idle_inputs();
    @(negedge Clk);
    check_val("tmo_stall_cnt", stalls, 16);
    check_val("tmo_err", {31'd0, timeout_err}, 32'd1);
    check_val("tmo_req_drop", {31'd0, dm_req}, 32'd0);
    check_val("tmo_stall", {31'd0, mem_stall}, 32'd0);
    check_val("tmo_regw", {31'd0, RegWrite_out}, 32'd0);
    @(negedge Clk);
    check_val("tmo_pulse", {31'd0, timeout_err}, 32'd0);
  endtask

  task automatic run_reset_mid_access();
    @(posedge Clk); #1;
    instruction_in = {6'h23, 26'd0}; hilowrite_in = 32'h80; MemRead_in = 1'b1;
    MemWrite_in = 1'b0; RegWrite_in = 1'b1; WriteReg_in = 5'd3; stall_in = 1'b0;
    @(posedge Clk); #1;
    @(negedge Clk);
    check_val("rst_acc_req", {31'd0, dm_req}, 32'd1);
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0; dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    idle_inputs();
    @(negedge Clk);
    check_all_zero("rst_mid");
    @(posedge Clk); #1;
    dm_ack = 1'b0;
    @(negedge Clk);
    check_val("rst_late_ack_valid", {31'd0, valid_out}, 32'd0);
    check_val("rst_late_ack_regw", {31'd0, RegWrite_out}, 32'd0);
  endtask

  logic [5:0] ops [9] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00};

  initial begin
    idle_inputs();
    dm_ack = 1'b0; dm_rdata = 32'd0; Rst = 1'b1;
    @(posedge Clk); @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    check_all_zero("reset");

    run_alu(32'h1234, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_mem(6'h20, 32'h103, 32'd0, 1'b0, 1'b1, 1'b1, 5'd7, 3, 32'h80FF_FFFF);
    run_mem(6'h29, 32'h202, 32'h0000_ABCD, 1'b1, 1'b0, 1'b1, 5'd2, 0, 32'd0);
    run_mem(6'h23, 32'h101, 32'd0, 1'b0, 1'b1, 1'b1, 5'd4, 1, 32'hCAFE_F00D);
    run_mem(6'h2B, 32'h300, 32'h1122_3344, 1'b1, 1'b1, 1'b1, 5'd6, 2, 32'd0);
    run_alu(32'h5555, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    run_reset_mid_access();
    run_timeout();

    for (int t = 0; t < 60; t++) begin
      int kind = int'($urandom_range(0, 9));
      if (kind < 2) begin
        run_alu($urandom, 5'($urandom), 1'($urandom), 1'($urandom), kind == 1,
                1'($urandom), 1'($urandom));
      end else begin
        logic [5:0] op = ops[$urandom_range(0, 8)];
        logic st = (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
        run_mem(op, $urandom, $urandom, st, ~st | 1'($urandom), 1'($urandom),
                5'($urandom), int'($urandom_range(0, 5)), $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
